regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single write path into the CPU's bank of 16-bit registers between several requesters (ALU writeback, memory load return, I/O input). Each cycle it picks at most one valid write request, decodes the destination address into a one-hot register enable, and presents the enable and data from flops. The flops are timed so that every register in the bank captures cleanly on its falling-edge write. Sits between the execute/memory stages and the register-bank instances.

## Interface
- NREQ, 3, number of write requesters (2..8)
- NREG, 8, number of registers in the bank (power of two, ≥2)
- W, 16, data width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  pipeline freeze; no request is accepted while high
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*log2(NREG)  destination register per requester, requester i in slice i
- req_data  in  NREQ*W  write data per requester, requester i in slice i
- req_ready  out  NREQ  grant; combinational, at most one bit high
- rf_en  out  NREG  registered one-hot write enable to the register bank
- rf_data  out  W  registered write data, shared by all registers
- wr_busy  out  1  registered; high in any cycle where rf_en is nonzero

## Operation
- Pick: candidate set = {i : req_valid[i]}. If stall=1 or the set is empty, req_ready=0.
- Otherwise exactly one req_ready[i]=1, chosen by round-robin from pointer ptr: the first valid index scanning ptr, ptr+1, … mod NREQ.
- Transfer: a transfer occurs on a rising edge where req_valid[i] & req_ready[i].
  - On transfer: rf_en ← onehot(req_addr[i]), rf_data ← req_data[i], wr_busy ← 1, ptr ← (i+1) mod NREQ.
- No transfer on an edge: rf_en ← 0, wr_busy ← 0. rf_data holds its last value. ptr is unchanged.
- Requesters must hold valid, addr and data stable until granted. Dropping valid before the grant is legal; the request is simply withdrawn.
- Same-address requests from two requesters are serialized in grant order. The last write wins in the bank.
- Maximum throughput is one write per cycle. A requester held continuously valid is granted at least once every NREQ cycles.
- Reset:
  - rf_en=0, rf_data=0, wr_busy=0, ptr=0.
  - req_ready=0 while rst is high.
  - A write staged in the output flops at reset assertion is discarded.

## Timing
- Grant latency: req_ready rises combinationally in the same cycle valid is seen, when that requester is selected and stall=0.
- Write latency: transfer at rising edge k → rf_en/rf_data valid through cycle k..k+1 → register bank captures at the falling edge inside that cycle → register output reflects the new value at rising edge k+1 relative to the transfer cycle, i.e. 2 edges after the transfer edge.
- rf_en is a 1-cycle pulse per transfer. Back-to-back transfers give rf_en nonzero on consecutive cycles.
- stall rising mid-stream: the write already staged still completes. No new grant is issued until stall falls.
- NREQ not a power of two: the pointer wraps from NREQ-1 to 0 explicitly.

## Configuration
- REGWR_ARB_FIXED_PRIO_EN defined: fixed priority. The lowest valid index always wins, ptr is not implemented, and starvation of high indices is permitted.
- REGWR_ARB_FIXED_PRIO_EN undefined (default): round-robin as specified above.

## Structure
- Package regwr_pkg holds:
  - REG_W=16
  - default NREQ/NREG
  - localparam ADDR_W=$clog2(NREG)
  - function onehot decode
- Sub-module rr_picker holds the combinational round-robin/fixed-priority selector. It takes valid and ptr and returns a one-hot grant plus the granted index.
- The top level holds the ptr flop, output flops and handshake logic.

## Test plan
- Reset: assert rst for 2 cycles with all req_valid=1 → req_ready=0, rf_en=0, rf_data=0, wr_busy=0. The first grant after release goes to requester 0.
- Single write: requester 1 valid, addr=5, data=16'hBEEF → req_ready=3'b010 the same cycle; next cycle rf_en=8'b0010_0000, rf_data=16'hBEEF, wr_busy=1; the cycle after, rf_en=0.
- Fairness: all three requesters held valid for 6 cycles → grant order 0,1,2,0,1,2, and rf_en is nonzero on all 6 following cycles.
- Stall: requester 2 valid, stall=1 for 3 cycles → req_ready=0 and rf_en=0 throughout. Stall falls → granted that cycle, and the write pulses on the next.
- Same-address collision: req0 addr=3 data=16'h1111 and req1 addr=3 data=16'h2222, both valid from reset → two consecutive rf_en=8'b0000_1000 pulses, and register 3 ends at 16'h2222.
- Fixed-priority build (REGWR_ARB_FIXED_PRIO_EN): req0 and req1 held valid for 4 cycles → req0 is granted all 4 cycles and req1 never is.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and the address-to-one-hot decode for the register-bank write arbiter.
// Optional build macro: REGWR_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
package regwr_pkg;

  localparam int REG_W      = 16;
  localparam int DEF_NREQ   = 3;
  localparam int DEF_NREG   = 8;
  localparam int ADDR_W     = $clog2(DEF_NREG);

  // Decode is sized for the largest bank we support; callers truncate to NREG.
  localparam int MAX_ADDR_W = 8;
  localparam int MAX_NREG   = 1 << MAX_ADDR_W;

  function automatic logic [MAX_NREG-1:0] onehot(input logic [MAX_ADDR_W-1:0] addr);
    logic [MAX_NREG-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_picker.sv
// Combinational requester selector: round-robin from ptr, or lowest-index-wins when
// REGWR_ARB_FIXED_PRIO_EN is defined (no ptr port in that build).
module rr_picker #(
  parameter int NREQ  = 3,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  valid,
`ifndef REGWR_ARB_FIXED_PRIO_EN
  input  logic [PTR_W-1:0] ptr,
`endif
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

`ifndef REGWR_ARB_FIXED_PRIO_EN
  logic [PTR_W-1:0] w_cand [NREQ];

  // Scan order ptr, ptr+1, ... with an explicit wrap so non-power-of-two NREQ works.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
      always_comb begin
        int s;
        s = int'(ptr) + gi;
        if (s >= NREQ) s = s - NREQ;
        w_cand[gi] = PTR_W'(s);
      end
    end
  endgenerate

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (valid[w_cand[k]]) begin
        idx = w_cand[k];
        any = 1'b1;
      end
    end
  end
`else
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (valid[k]) begin
        idx = PTR_W'(k);
        any = 1'b1;
      end
    end
  end
`endif

  assign grant = any ? (NREQ'(1) << idx) : '0;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Single write port into the register bank: picks one requester per cycle and stages a
// one-hot enable plus data in flops for the bank's falling-edge capture.
// Optional build macro: REGWR_ARB_FIXED_PRIO_EN.
module regfile_write_arbiter
  import regwr_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int NREG = DEF_NREG,
  parameter int W    = REG_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*$clog2(NREG)-1:0]  req_addr,
  input  logic [NREQ*W-1:0]             req_data,
  output logic [NREQ-1:0]               req_ready,
  output logic [NREG-1:0]               rf_en,
  output logic [W-1:0]                  rf_data,
  output logic                          wr_busy
);

  localparam int A_W   = $clog2(NREG);
  localparam int PTR_W = $clog2(NREQ);

  logic [NREQ-1:0]  w_grant;
  logic [PTR_W-1:0] w_idx;
  logic             w_any;
  logic             w_xfer;
  logic [A_W-1:0]   w_sel_addr;
  logic [W-1:0]     w_sel_data;

  logic [NREG-1:0]  r_en;
  logic [W-1:0]     r_data;
  logic             r_busy;

`ifndef REGWR_ARB_FIXED_PRIO_EN
  logic [PTR_W-1:0] r_ptr;
`endif

  rr_picker #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .valid (req_valid),
`ifndef REGWR_ARB_FIXED_PRIO_EN
    .ptr   (r_ptr),
`endif
    .grant (w_grant),
    .idx   (w_idx),
    .any   (w_any)
  );

  // A grant is always a transfer: the picker only selects valid requesters.
  assign w_xfer     = w_any & ~stall & ~rst;
  assign req_ready  = w_xfer ? w_grant : '0;
  assign w_sel_addr = req_addr[w_idx*A_W +: A_W];
  assign w_sel_data = req_data[w_idx*W +: W];

`ifndef REGWR_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= (w_idx == PTR_W'(NREQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end
`endif

  // rf_data deliberately holds between writes; only the enable pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en   <= '0;
      r_data <= '0;
      r_busy <= 1'b0;
    end else if (w_xfer) begin
      r_en   <= NREG'(onehot(MAX_ADDR_W'(w_sel_addr)));
      r_data <= w_sel_data;
      r_busy <= 1'b1;
    end else begin
      r_en   <= '0;
      r_busy <= 1'b0;
    end
  end

  assign rf_en   = r_en;
  assign rf_data = r_data;
  assign wr_busy = r_busy;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: stimulus pushes expected output-flop contents; a monitor pops and compares.
module tb_regfile_write_arbiter;
  localparam int NREQ = 3;
  localparam int NREG = 8;
  localparam int W    = 16;
  localparam int AW   = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 stall;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*W-1:0]    req_data;
  logic [NREQ-1:0]      req_ready;
  logic [NREG-1:0]      rf_en;
  logic [W-1:0]         rf_data;
  logic                 wr_busy;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.NREQ(NREQ), .NREG(NREG), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_en     (rf_en),
    .rf_data   (rf_data),
    .wr_busy   (wr_busy)
  );

  typedef struct {
    logic [NREG-1:0] en;
    logic [W-1:0]    data;
    logic            busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference state: pointer, last written data, and the bank contents implied by grants.
  int          m_ptr  = 0;
  logic [W-1:0] m_data = '0;
  logic [W-1:0] m_bank [NREG];
  logic [W-1:0] tb_bank[NREG];

  int v[NREQ];
  int a[NREQ];
  int d[NREQ];
  int last_g;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  function automatic int pick();
    int j;
`ifdef REGWR_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++) if (v[k] != 0) return k;
`else
    for (int k = 0; k < NREQ; k++) begin
      j = (m_ptr + k) % NREQ;
      if (v[j] != 0) return j;
    end
`endif
    return -1;
  endfunction

  // One clock cycle of stimulus: drive, check the combinational grant, predict the flops.
  task automatic apply(input int st, input int r);
    int g;
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]           = (v[i] != 0);
      req_addr[i*AW +: AW]   = AW'(a[i]);
      req_data[i*W +: W]     = W'(d[i]);
    end
    stall = st[0];
    rst   = r[0];
    #1;
    g = (r == 0 && st == 0) ? pick() : -1;
    chk("req_ready", 64'(req_ready), (g >= 0) ? 64'(1) << g : 64'(0));
    if (r != 0) begin
      m_ptr  = 0;
      m_data = '0;
      e = '{en: '0, data: '0, busy: 1'b0};
    end else if (g >= 0) begin
      m_bank[a[g]] = W'(d[g]);
      m_data       = W'(d[g]);
      m_ptr        = (g + 1) % NREQ;
      e = '{en: NREG'(1) << a[g], data: W'(d[g]), busy: 1'b1};
    end else begin
      e = '{en: '0, data: m_data, busy: 1'b0};
    end
    exp_q.push_back(e);
    $display("cyc=%0d rst=%0d stall=%0d valid=%b grant=%0d ready=%b", cyc, r, st, req_valid, g, req_ready);
    last_g = g;
    cyc++;
  endtask

  task automatic new_req(input int i);
    v[i] = ($urandom_range(0, 99) < 60) ? 1 : 0;
    a[i] = $urandom_range(0, NREG - 1);
    d[i] = $urandom_range(0, 65535);
  endtask

  task automatic set_req(input int i, input int vv, input int aa, input int dd);
    v[i] = vv; a[i] = aa; d[i] = dd;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rf_en", 64'(rf_en), 64'(e.en));
      chk("rf_data", 64'(rf_data), 64'(e.data));
      chk("wr_busy", 64'(wr_busy), 64'(e.busy));
    end
  end

  // Behavioural register bank capturing on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < NREG; i++) if (rf_en[i] === 1'b1) tb_bank[i] = rf_data;
  end

  initial begin
    rst = 1'b1; stall = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    for (int i = 0; i < NREG; i++) begin m_bank[i] = '0; tb_bank[i] = '0; end
    for (int i = 0; i < NREQ; i++) set_req(i, 1, i, 16'h1000 + i);

    // Reset with everyone requesting, then first grant.
    apply(0, 1);
    apply(0, 1);
    apply(0, 0);
    chk("first_grant", 64'(req_ready), 64'(3'b001));
    for (int i = 0; i < NREQ; i++) v[i] = 0;
    apply(0, 0);

    // Single write.
    set_req(1, 1, 5, 16'hBEEF);
    apply(0, 0);
    chk("single_ready", 64'(req_ready), 64'(3'b010));
    v[1] = 0;
    apply(0, 0);
    apply(0, 0);

    // Fairness: all held valid, fresh data after each grant.
    for (int i = 0; i < NREQ; i++) set_req(i, 1, $urandom_range(0, NREG - 1), $urandom_range(0, 65535));
    for (int c = 0; c < 6; c++) begin
      apply(0, 0);
      if (last_g >= 0) set_req(last_g, 1, $urandom_range(0, NREG - 1), $urandom_range(0, 65535));
    end
    for (int i = 0; i < NREQ; i++) v[i] = 0;
    apply(0, 0);

    // Stall holds off requester 2, then it goes through.
    set_req(2, 1, 6, 16'h5A5A);
    repeat (3) apply(1, 0);
    apply(0, 0);
    chk("stall_release", 64'(req_ready), 64'(3'b100));
    v[2] = 0;
    apply(0, 0);

    // Same-address collision from reset.
    set_req(0, 1, 3, 16'h1111);
    set_req(1, 1, 3, 16'h2222);
    apply(0, 1);
    for (int c = 0; c < 4; c++) begin
      apply(0, 0);
      if (last_g >= 0) v[last_g] = 0;
    end
    chk("collision_bank3", 64'(tb_bank[3]), 64'(16'h2222));

`ifdef REGWR_ARB_FIXED_PRIO_EN
    set_req(0, 1, 1, 16'hAAAA);
    set_req(1, 1, 2, 16'hBBBB);
    for (int c = 0; c < 4; c++) begin
      apply(0, 0);
      chk("fixed_prio", 64'(req_ready), 64'(3'b001));
    end
    for (int i = 0; i < NREQ; i++) v[i] = 0;
`endif

    // Randomized phase with legal withdrawals, stalls and occasional mid-stream resets.
    for (int i = 0; i < NREQ; i++) new_req(i);
    for (int c = 0; c < 400; c++) begin
      apply(($urandom_range(0, 99) < 20) ? 1 : 0, ($urandom_range(0, 99) < 2) ? 1 : 0);
      for (int i = 0; i < NREQ; i++) begin
        if (last_g == i || v[i] == 0) new_req(i);
        else if ($urandom_range(0, 99) < 5) v[i] = 0;
      end
    end

    for (int i = 0; i < NREQ; i++) v[i] = 0;
    repeat (3) apply(0, 0);
    repeat (4) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    for (int i = 0; i < NREG; i++) chk("bank", 64'(tb_bank[i]), 64'(m_bank[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
